// File: rtl/delay_event_sched_pkg.sv
// Shared types, default widths and the round-robin search helper for
// the delay event scheduler.
package delay_event_sched_pkg;

    localparam int N_SLOTS_DEF = 4;
    localparam int DW_DEF      = 8;
    localparam int IDW_DEF     = 4;

    // Width of the occupancy count: it must be able to hold N_SLOTS itself
    localparam int OCC_W_DEF   = $clog2(N_SLOTS_DEF + 1);

    // Pending-event slot layout at the default widths; the slot counter
    // declares the same layout at its own parameterised widths.
    typedef struct packed {
        logic                valid;
        logic [DW_DEF-1:0]   cnt;
        logic [IDW_DEF-1:0]  id;
    } slot_t;

    // Round-robin first-set search over the low n bits of req, starting at
    // ptr and wrapping. Result bit 4 = found, bits 3:0 = chosen index.
    function automatic logic [4:0] rr_first_set(input logic [15:0] req,
                                                input logic [3:0]  ptr,
                                                input int          n);
        logic [4:0] res;
        int         j;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < n) begin
                j = (int'(ptr) + i) % n;
                if (!res[4] && req[4'(j)]) begin
                    res = {1'b1, 4'(j)};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sched_slot_counter.sv
// One pending-event slot: loads a delay and ID, counts down to zero,
// reports eligibility, and frees on issue or flush.
module sched_slot_counter
    import delay_event_sched_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int IDW = IDW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_flush,
    input  logic           i_load,
    input  logic [DW-1:0]  i_delay,
    input  logic [IDW-1:0] i_id,
    input  logic           i_clear,
    output logic           o_valid,
    output logic           o_eligible,
    output logic [IDW-1:0] o_id
);

    typedef struct packed {
        logic           valid;
        logic [DW-1:0]  cnt;
        logic [IDW-1:0] id;
    } slot_q_t;

    slot_q_t r_slot;

    // Slot state: flush beats load, load only happens into a free slot so
    // it never coincides with clear, and the counter saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot <= '0;
        end else if (i_flush) begin
            r_slot.valid <= 1'b0;
        end else if (i_load) begin
            r_slot <= '{valid: 1'b1, cnt: i_delay, id: i_id};
        end else if (i_clear) begin
            r_slot.valid <= 1'b0;
        end else if (r_slot.valid && (r_slot.cnt != '0)) begin
            r_slot.cnt <= r_slot.cnt - DW'(1);
        end
    end

    assign o_valid    = r_slot.valid;
    assign o_eligible = r_slot.valid && (r_slot.cnt == '0);
    assign o_id       = r_slot.id;

endmodule

// File: rtl/delay_event_scheduler.sv
// Cycle-counted event scheduler: N_SLOTS countdown slots, lowest-free
// allocation, round-robin issue of expired events through a valid/ready
// output register.
module delay_event_scheduler
    import delay_event_sched_pkg::*;
#(
    parameter int N_SLOTS = N_SLOTS_DEF,
    parameter int DW      = DW_DEF,
    parameter int IDW     = IDW_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [DW-1:0]                  req_delay,
    input  logic [IDW-1:0]                 req_id,
    output logic                           fire_valid,
    input  logic                           fire_ready,
    output logic [IDW-1:0]                 fire_id,
    output logic [$clog2(N_SLOTS+1)-1:0]   occupancy,
    output logic                           busy
);

    localparam int PW = $clog2(N_SLOTS);
    localparam int OW = $clog2(N_SLOTS + 1);

    logic [N_SLOTS-1:0] w_valid;
    logic [N_SLOTS-1:0] w_elig;
    logic [N_SLOTS-1:0] w_load;
    logic [N_SLOTS-1:0] w_clear;
    logic [IDW-1:0]     w_slot_id [N_SLOTS];
    logic [PW-1:0]      w_alloc;
    logic [PW-1:0]      w_pick;
    logic [4:0]         w_rr;
    logic               w_any_free;
    logic               w_accept;
    logic               w_found;
    logic               w_loadable;
    logic               w_issue;
    logic [OW-1:0]      w_occ;

    logic [PW-1:0]      r_ptr;
    logic               r_fire_valid;
    logic [IDW-1:0]     r_fire_id;

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        sched_slot_counter #(.DW(DW), .IDW(IDW)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .i_flush    (flush),
            .i_load     (w_load[g]),
            .i_delay    (req_delay),
            .i_id       (req_id),
            .i_clear    (w_clear[g]),
            .o_valid    (w_valid[g]),
            .o_eligible (w_elig[g]),
            .o_id       (w_slot_id[g])
        );
    end

    // Lowest-index free slot; scanning downward lets the lowest win.
    always_comb begin
        w_alloc    = '0;
        w_any_free = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_alloc    = PW'(i);
                w_any_free = 1'b1;
            end
        end
    end

    assign req_ready  = w_any_free && !flush;
    assign w_accept   = req_valid && req_ready;

    assign w_rr       = rr_first_set(16'(w_elig), 4'(r_ptr), N_SLOTS);
    assign w_found    = w_rr[4];
    assign w_pick     = PW'(w_rr[3:0]);
    assign w_loadable = !r_fire_valid || fire_ready;
    assign w_issue    = w_loadable && w_found && !flush;

    // Per-slot load and clear strobes decoded from the chosen indices.
    always_comb begin
        w_load  = '0;
        w_clear = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_load[i]  = w_accept && (w_alloc == PW'(i));
            w_clear[i] = w_issue  && (w_pick  == PW'(i));
        end
    end

    // Output register: holds under backpressure, refills or empties when
    // the consumer has taken the current event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fire_valid <= 1'b0;
            r_fire_id    <= '0;
        end else if (flush) begin
            r_fire_valid <= 1'b0;
        end else if (w_loadable) begin
            r_fire_valid <= w_found;
            if (w_found) begin
                r_fire_id <= w_slot_id[w_pick];
            end
        end
    end

    // Round-robin pointer advances past each issued slot; flush leaves it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= PW'((int'(w_pick) + 1) % N_SLOTS);
        end
    end

    // Occupancy is the population count of valid slots.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_occ = w_occ + OW'(w_valid[i]);
        end
    end

    assign fire_valid = r_fire_valid;
    assign fire_id    = r_fire_id;
    assign occupancy  = w_occ;
    assign busy       = (w_occ != '0) || r_fire_valid;

endmodule

// File: tb/tb_delay_event_scheduler.sv
// Scoreboard bench for delay_event_scheduler: stimulus pushes expected
// {id, cycle} fires; a monitor pops and compares on every handshake.
module tb_delay_event_scheduler;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           req_valid;
    logic           req_ready;
    logic [DW-1:0]  req_delay;
    logic [IDW-1:0] req_id;
    logic           fire_valid;
    logic           fire_ready;
    logic [IDW-1:0] fire_id;
    logic [2:0]     occupancy;
    logic           busy;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int id;
        int cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    delay_event_scheduler #(.N_SLOTS(N), .DW(DW), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_delay  (req_delay),
        .req_id     (req_id),
        .fire_valid (fire_valid),
        .fire_ready (fire_ready),
        .fire_id    (fire_id),
        .occupancy  (occupancy),
        .busy       (busy)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; acc is the cycle
    // count right after the accepting edge.
    task automatic post(input int id, input int d, output int acc);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_id    = IDW'(id);
        req_delay = DW'(d);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        if (!ok) chk("post_accept_timeout", 0, 1);
    endtask

    task automatic push(input int id, input int c);
        exp_t e;
        e.id  = id;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (!busy && sb.size() == 0) ok = 1'b1;
            else tick();
        end
        chk(name, int'(ok), 1);
    endtask

    // Monitor: every accepted fire must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && fire_valid && fire_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_fire: got id %0d at cycle %0d required no fire", fire_id, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("fire_id", int'(fire_id), e.id);
                    chk("fire_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a0, a5, b, c;

        rst        = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_delay  = '0;
        req_id     = '0;
        fire_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_fire_valid", int'(fire_valid), 0);
        chk("rst_fire_id",    int'(fire_id),    0);
        chk("rst_occupancy",  int'(occupancy),  0);
        chk("rst_busy",       int'(busy),       0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_req_ready", int'(req_ready), 1);

        // Single event, delay 3
        post(5, 3, a);
        push(5, a + 4);
        chk("t1_occ_after_accept", int'(occupancy), 1);
        repeat (3) tick();
        chk("t1_not_yet", int'(fire_valid), 0);
        tick();
        chk("t1_fire_valid", int'(fire_valid), 1);
        chk("t1_fire_id",    int'(fire_id),    5);
        chk("t1_occ_after_issue", int'(occupancy), 0);
        tick();
        chk("t1_fire_drop", int'(fire_valid), 0);
        chk("t1_busy_low",  int'(busy),       0);

        // Zero delay
        post(2, 0, a);
        push(2, a + 1);
        chk("t2_occ", int'(occupancy), 1);
        chk("t2_no_fire_yet", int'(fire_valid), 0);
        tick();
        chk("t2_fire_valid", int'(fire_valid), 1);
        chk("t2_fire_id",    int'(fire_id),    2);
        chk("t2_busy_high",  int'(busy),       1);
        tick();
        chk("t2_busy_low", int'(busy), 0);

        // Fill and stall
        post(0, 10, a0);
        push(0, a0 + 11);
        for (int k = 1; k < 4; k++) begin
            post(k, 10, a);
            push(k, a + 11);
        end
        chk("t3_occ_full",   int'(occupancy), 4);
        chk("t3_ready_full", int'(req_ready), 0);
        post(9, 5, a5);
        chk("t3_stall_accept_cycle", a5, a0 + 12);
        push(9, a5 + 6);
        wait_idle("t3_drain");

        // Async reset with pending events and a presented fire
        fire_ready = 1'b0;
        post(10, 0, c);
        post(11, 6, c);
        post(12, 6, c);
        chk("t6_occ_before", int'(occupancy), 2);
        chk("t6_fire_before", int'(fire_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_fire_valid_clear", int'(fire_valid), 0);
        chk("t6_fire_id_clear",    int'(fire_id),    0);
        chk("t6_occ_clear",        int'(occupancy),  0);
        chk("t6_busy_clear",       int'(busy),       0);
        #1;
        rst        = 1'b1;
        fire_ready = 1'b1;
        repeat (15) tick();
        chk("t6_no_late_fire", int'(fire_valid), 0);
        chk("t6_occ_after",    int'(occupancy),  0);

        // Contention with backpressure: ids 1,2,3 expire on one edge
        post(1, 5, a);
        post(2, 4, c);
        post(3, 3, c);
        push(1, a + 9);
        push(2, a + 10);
        push(3, a + 11);
        fire_ready = 1'b0;
        repeat (3) tick();
        chk("t4_occ_expired", int'(occupancy), 3);
        chk("t4_not_loaded",  int'(fire_valid), 0);
        tick();
        chk("t4_hold0_valid", int'(fire_valid), 1);
        chk("t4_hold0_id",    int'(fire_id),    1);
        chk("t4_hold0_occ",   int'(occupancy),  2);
        tick();
        chk("t4_hold1_id", int'(fire_id), 1);
        tick();
        chk("t4_hold2_id", int'(fire_id), 1);
        chk("t4_hold2_occ", int'(occupancy), 2);
        tick();
        fire_ready = 1'b1;
        wait_idle("t4_drain");

        // Flush mid-count with a concurrent request
        post(4, 8, b);
        post(5, 8, c);
        post(6, 8, c);
        tick();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_id    = 4'd7;
        req_delay = 8'd1;
        #1;
        chk("t5_ready_during_flush", int'(req_ready), 0);
        chk("t5_occ_before_flush",   int'(occupancy), 3);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("t5_occ_flushed",  int'(occupancy),  0);
        chk("t5_fire_flushed", int'(fire_valid), 0);
        chk("t5_busy_flushed", int'(busy),       0);
        repeat (15) tick();
        chk("t5_no_late_fire", int'(fire_valid), 0);
        chk("t5_occ_after",    int'(occupancy),  0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
